alu_req_scheduler: RTL and testbench



---
 rtl/alu_req_scheduler.sv | 156 +++++++++++++++
 tb/tb_alu_req_scheduler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_scheduler.sv
// -----------------------------------------------------------------------------
// alu_req_scheduler
//
// Shares one ALU datapath between two requesters. A request is granted in
// IDLE, its operands/opcode are latched onto the ALU inputs, alu_en is held
// for SETTLE cycles plus one capture cycle, the ALU result is registered and
// returned to the owning requester as a one-cycle response pulse.
//
// Build option:
//   ALU_SCHED_RR_EN  defined   -> round-robin arbitration between requesters
//                    undefined -> fixed priority, requester 0 wins
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req{0,1}_valid/_ready           request handshake
//   req{0,1}_a/_b/_op               request operands and opcode
//   rsp{0,1}_valid                  one-cycle response pulse per requester
//   rsp_result, rsp_carry           captured ALU result/carry (shared)
//   alu_en                          operand-enable gating to the ALU
//   alu_a, alu_b, alu_op            latched operands/opcode to the ALU
//   alu_result, alu_carry           ALU outputs
// -----------------------------------------------------------------------------
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for a request; one requester may see ready
// S_SETTLE | alu_en high, settle counter running down
// S_CAPTURE| alu_en high, ALU result registered at end of cycle
// S_RESP   | response pulse to owner, alu_en low
// -----------------------------------------------------------------------------
module alu_req_scheduler #(
  parameter int WIDTH  = 4,
  parameter int OP_W   = 3,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OP_W-1:0]  req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OP_W-1:0]  req1_op,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             alu_en,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic       r_owner;
  logic       w_idle;
  logic       w_grant1;
  logic       w_accept;

`ifdef ALU_SCHED_RR_EN
  logic r_last_grant;

  // On contention the requester that did not win last time is granted.
  assign w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_last_grant <= w_grant1;
    end
  end
`else
  assign w_grant1 = req1_valid & ~req0_valid;
`endif

  assign w_idle     = (r_state == S_IDLE);
  assign w_accept   = w_idle & (req0_valid | req1_valid);
  assign req0_ready = w_idle & req0_valid & ~w_grant1;
  assign req1_ready = w_idle & w_grant1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    alu_en     = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_SETTLE;
      end
      S_SETTLE: begin
        alu_en = 1'b1;
        if (r_cnt == 4'd0) w_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        alu_en = 1'b1;
        w_next = S_RESP;
      end
      S_RESP: begin
        rsp0_valid = ~r_owner;
        rsp1_valid = r_owner;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      r_owner    <= 1'b0;
      r_cnt      <= 4'd0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
    end else begin
      if (w_accept) begin
        alu_a   <= w_grant1 ? req1_a  : req0_a;
        alu_b   <= w_grant1 ? req1_b  : req0_b;
        alu_op  <= w_grant1 ? req1_op : req0_op;
        r_owner <= w_grant1;
        r_cnt   <= 4'(SETTLE - 1);
      end else if ((r_state == S_SETTLE) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == S_CAPTURE) begin
        rsp_result <= alu_result;
        rsp_carry  <= alu_carry;
      end
    end
  end

endmodule

// File: tb/tb_alu_req_scheduler.sv
module tb_alu_req_scheduler;
  localparam int WIDTH  = 4;
  localparam int OP_W   = 3;
  localparam int SETTLE = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OP_W-1:0]  req0_op, req1_op;
  logic             rsp0_valid, rsp1_valid;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry;
  logic             alu_en;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [OP_W-1:0]  alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [5:0] sb[$];   // {owner, carry, result}

  alu_req_scheduler #(.WIDTH(WIDTH), .OP_W(OP_W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry),
    .alu_en(alu_en), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // 0 ADD, 1 SUB (carry = borrow), 2 AND, 3 OR, 4 XOR, others pass a
  function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] op);
    case (op)
      3'd0:    alu_f = {1'b0, a} + {1'b0, b};
      3'd1:    alu_f = {1'b0, a} - {1'b0, b};
      3'd2:    alu_f = {1'b0, a & b};
      3'd3:    alu_f = {1'b0, a | b};
      3'd4:    alu_f = {1'b0, a ^ b};
      default: alu_f = {1'b0, a};
    endcase
  endfunction

  // ALU behind the enable stage: operands read as zero while alu_en is low.
  always_comb begin
    {alu_carry, alu_result} = 5'd0;
    if (alu_en) {alu_carry, alu_result} = alu_f(alu_a, alu_b, alu_op);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on accept, pop on response pulse.
  always @(negedge clk) begin
    logic [5:0] e;
    if (rst_n) begin
      if (req0_valid && req0_ready) sb.push_back({1'b0, alu_f(req0_a, req0_b, req0_op)});
      if (req1_valid && req1_ready) sb.push_back({1'b1, alu_f(req1_a, req1_b, req1_op)});
      if (req0_ready || req1_ready) chk("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
      if (rsp0_valid || rsp1_valid) begin
        chk("rsp_both", 32'(rsp0_valid & rsp1_valid), 32'd0);
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_owner", 32'(rsp1_valid), 32'(e[5]));
          chk("rsp_data", 32'({rsp_carry, rsp_result}), 32'(e[4:0]));
        end
      end
    end
  end

  task automatic wait_ready(input bit id, output int t, output bit ok);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        t  = cyc;
        ok = 1'b1;
        return;
      end
    end
    chk("ready_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int  t, tp, n_ops;
    bit  ok, g, found;

    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req0_op = 0;
    req1_a = 0; req1_b = 0; req1_op = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_alu_en", 32'(alu_en), 32'd0);
    chk("rst_alu_opnds", 32'({alu_a, alu_b, alu_op}), 32'd0);
    chk("rst_rsp", 32'({rsp0_valid, rsp1_valid, rsp_carry, rsp_result}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single op: 3 + 5 = 8, carry 0
    req0_a = 4'h3; req0_b = 4'h5; req0_op = 3'd0; req0_valid = 1;
    wait_ready(0, t, ok);
    chk("t1_req1_ready", 32'(req1_ready), 32'd0);
    @(posedge clk); #1 req0_valid = 0;
    for (int k = 1; k <= SETTLE + 2; k++) begin
      @(negedge clk);
      chk("t1_alu_en", 32'(alu_en), 32'(k <= SETTLE + 1));
      chk("t1_rsp0", 32'(rsp0_valid), 32'(k == SETTLE + 2));
      chk("t1_rsp1", 32'(rsp1_valid), 32'd0);
      if (k == 1) chk("t1_alu_opnds", 32'({alu_a, alu_b}), 32'h35);
    end
    chk("t1_result", 32'({rsp_carry, rsp_result}), 32'h08);
    @(negedge clk);
    chk("t1_result_hold", 32'({rsp_carry, rsp_result}), 32'h08);
    chk("t1_rsp0_pulse", 32'(rsp0_valid), 32'd0);

    // Busy rejection: req1 raised one cycle after req0 accept
    req0_a = 4'h9; req0_b = 4'h9; req0_op = 3'd0; req0_valid = 1;
    wait_ready(0, t, ok);
    @(posedge clk); #1 req0_valid = 0;
    req1_a = 4'h6; req1_b = 4'h3; req1_op = 3'd1; req1_valid = 1;
    for (int k = 1; k <= SETTLE + 3; k++) begin
      @(negedge clk);
      chk("busy_r1_ready", 32'(req1_ready), 32'(k == SETTLE + 3));
    end
    @(posedge clk); #1 req1_valid = 0;
    repeat (SETTLE + 3) @(posedge clk);
    #1 chk("busy_sb_drain", 32'(sb.size()), 32'd0);

    // Contention: both valid continuously
`ifdef ALU_SCHED_RR_EN
    n_ops = 4;
`else
    n_ops = 3;
`endif
    req0_a = 4'h1; req0_b = 4'h2; req0_op = 3'd0;
    req1_a = 4'h7; req1_b = 4'h1; req1_op = 3'd4;
    req0_valid = 1; req1_valid = 1;
    tp = 0;
    for (int i = 0; i < n_ops; i++) begin
      found = 0;
      g = 0;
      for (int j = 0; j < 20 && !found; j++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) begin
          found = 1;
          g = req1_ready;
          t = cyc;
        end
      end
      if (!found) begin
        chk("cont_timeout", 32'd0, 32'd1);
        break;
      end
`ifdef ALU_SCHED_RR_EN
      chk("cont_grant", 32'(g), 32'(i % 2));
`else
      chk("cont_grant", 32'(g), 32'd0);
`endif
      if (i > 0) chk("cont_spacing", 32'(t - tp), 32'(SETTLE + 3));
      tp = t;
      @(posedge clk); #1;
      if (g) req1_a = req1_a + 4'd3;
      else   req0_a = req0_a + 4'd5;
    end
    req0_valid = 0; req1_valid = 0;
    repeat (SETTLE + 4) @(posedge clk);
    #1 chk("cont_sb_drain", 32'(sb.size()), 32'd0);

    // Reset mid-operation
    req0_a = 4'hF; req0_b = 4'h1; req0_op = 3'd0; req0_valid = 1;
    wait_ready(0, t, ok);
    @(posedge clk); #1 req0_valid = 0;
    @(posedge clk); #1;
    chk("mid_alu_en_before", 32'(alu_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_alu_en", 32'(alu_en), 32'd0);
    chk("mid_alu_opnds", 32'({alu_a, alu_b, alu_op}), 32'd0);
    chk("mid_rsp", 32'({rsp0_valid, rsp1_valid, rsp_carry, rsp_result}), 32'd0);
    chk("mid_ready", 32'({req0_ready, req1_ready}), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("mid_no_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
      chk("mid_no_en", 32'(alu_en), 32'd0);
    end
    req1_a = 4'hC; req1_b = 4'h6; req1_op = 3'd2; req1_valid = 1;
    wait_ready(1, t, ok);
    @(posedge clk); #1 req1_valid = 0;
    for (int k = 1; k <= SETTLE + 2; k++) begin
      @(negedge clk);
      chk("post_rst_rsp1", 32'(rsp1_valid), 32'(k == SETTLE + 2));
    end
    chk("post_rst_result", 32'({rsp_carry, rsp_result}), 32'h04);
    repeat (2) @(posedge clk);
    #1 chk("post_rst_sb_drain", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
